// File: rtl/counter_day_31.sv
// Day-of-month counter (1..28/29/30/31) with a registered end-of-month carry.
// Build option: define LEAP_YEAR_EN so that February has 29 days when year_mod4 == 0.
module counter_day_31 #(
  parameter int unsigned RESET_DAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_auto,
  input  logic       inc_manual,
  input  logic       dec_manual,
  input  logic [3:0] month,
  input  logic [1:0] year_mod4,
  output logic [4:0] value,
  output logic       carry_out,
  output logic [4:0] days_max
);

  localparam logic [4:0] RESET_VAL = 5'(RESET_DAY);

  logic [4:0] value_q, value_d;
  logic       carry_q, carry_d;

  always_comb begin
    days_max = 5'd31;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days_max = 5'd30;
`ifdef LEAP_YEAR_EN
      4'd2: days_max = (year_mod4 == 2'd0) ? 5'd29 : 5'd28;
`else
      4'd2: days_max = 5'd28;
`endif
      default: days_max = 5'd31;
    endcase
  end

`ifndef LEAP_YEAR_EN
  // year_mod4 has no function in this build; keep it visibly unloaded.
  logic unused_year_mod4;
  assign unused_year_mod4 = ^year_mod4;
`endif

  // Only the highest-priority request is acted on; the rest are dropped.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (value_q > days_max) begin
      value_d = days_max;
    end else if (dec_manual) begin
      value_d = (value_q == 5'd1) ? days_max : value_q - 5'd1;
    end else if (inc_manual) begin
      value_d = (value_q >= days_max) ? 5'd1 : value_q + 5'd1;
    end else if (inc_auto) begin
      if (value_q >= days_max) begin
        value_d = 5'd1;
        carry_d = 1'b1;
      end else begin
        value_d = value_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_counter_day_31.sv
// Scoreboard bench for counter_day_31: a calendar model queues expected day/carry
// per clock, and a monitor pops and compares after every rising edge.
module tb_counter_day_31;

  localparam int RESET_DAY = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inc_auto = 1'b0;
  logic       inc_manual = 1'b0;
  logic       dec_manual = 1'b0;
  logic [3:0] month = 4'd1;
  logic [1:0] year_mod4 = 2'd1;
  logic [4:0] value;
  logic       carry_out;
  logic [4:0] days_max;

  counter_day_31 #(.RESET_DAY(RESET_DAY)) dut (
    .clk        (clk),
    .rst        (rst),
    .inc_auto   (inc_auto),
    .inc_manual (inc_manual),
    .dec_manual (dec_manual),
    .month      (month),
    .year_mod4  (year_mod4),
    .value      (value),
    .carry_out  (carry_out),
    .days_max   (days_max)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int    day;
    int    carry;
    string tag;
  } exp_t;
  exp_t sb[$];

  int m_day = RESET_DAY;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int month_len(input int mon, input int ym);
    int len [16] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31, 31, 31, 31};
    if (mon == 2) begin
`ifdef LEAP_YEAR_EN
      return (ym == 0) ? 29 : 28;
`else
      return 28;
`endif
    end
    return len[mon];
  endfunction

  // One clock of stimulus: drive at negedge, check days_max, queue expected outcome.
  task automatic step(input string tag, input int r, input int ia, input int im,
                      input int dm, input int mon, input int ym);
    int lim, c;
    @(negedge clk);
    rst        = r[0];
    inc_auto   = ia[0];
    inc_manual = im[0];
    dec_manual = dm[0];
    month      = 4'(mon);
    year_mod4  = 2'(ym);
    #1;
    lim = month_len(mon, ym);
    check({tag, "/days_max"}, int'(days_max), lim);
    c = 0;
    if (r != 0)            m_day = RESET_DAY;
    else if (m_day > lim)  m_day = lim;
    else if (dm != 0)      m_day = (m_day == 1) ? lim : m_day - 1;
    else if (im != 0)      m_day = (m_day >= lim) ? 1 : m_day + 1;
    else if (ia != 0) begin
      if (m_day >= lim) begin m_day = 1; c = 1; end
      else m_day = m_day + 1;
    end
    sb.push_back('{day: m_day, carry: c, tag: tag});
  endtask

  task automatic set_day(input int target, input int mon, input int ym);
    for (int k = 0; k < 40 && m_day != target; k++)
      step("set", 0, 0, 1, 0, mon, ym);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "/value"}, int'(value), e.day);
        check({e.tag, "/carry_out"}, int'(carry_out), e.carry);
      end
    end
  end

  initial begin : stim
    int mon, ym, r;
    step("reset", 1, 0, 0, 0, 1, 1);
    step("reset", 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("hold", 0, 0, 0, 0, 1, 1);

    // January: 30 auto pulses to 31, then wrap with carry, then idle.
    for (int i = 0; i < 30; i++) step("jan_inc", 0, 1, 0, 0, 1, 1);
    step("jan_wrap", 0, 1, 0, 0, 1, 1);
    step("jan_after", 0, 0, 0, 0, 1, 1);

    // April wraps at 30, back-to-back pulses.
    for (int i = 0; i < 29; i++) step("apr_inc", 0, 1, 0, 0, 4, 1);
    step("apr_wrap", 0, 1, 0, 0, 4, 1);
    step("apr_after", 0, 1, 0, 0, 4, 1);

    // February, non-leap and leap-candidate year.
    set_day(28, 2, 1);
    step("feb_wrap", 0, 1, 0, 0, 2, 1);
    set_day(28, 2, 0);
    step("feb_leap_a", 0, 1, 0, 0, 2, 0);
    step("feb_leap_b", 0, 1, 0, 0, 2, 0);
    step("feb_leap_c", 0, 0, 0, 0, 2, 0);

    // Manual wrap both ways in June.
    set_day(1, 6, 1);
    step("jun_dec", 0, 0, 0, 1, 6, 1);
    step("jun_inc", 0, 0, 1, 0, 6, 1);

    // Clamp: month drops under day 31 while an auto pulse arrives.
    set_day(31, 1, 1);
    step("clamp", 0, 1, 0, 0, 2, 1);
    step("clamp_after", 0, 0, 0, 0, 2, 1);

    // Simultaneous pulses.
    set_day(10, 3, 1);
    step("all3", 0, 1, 1, 1, 3, 1);
    set_day(31, 3, 1);
    step("auto_man", 0, 1, 1, 0, 3, 1);

    // Reset on a carry cycle.
    set_day(31, 1, 1);
    step("rst_carry", 1, 1, 0, 0, 1, 1);

    // Random traffic with occasional month/year changes and resets.
    mon = 1; ym = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        mon = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 12));
        ym  = int'($urandom_range(0, 3));
      end
      r = ($urandom_range(0, 199) == 0) ? 1 : 0;
      step("rand", r,
           ($urandom_range(0, 99) < 60) ? 1 : 0,
           ($urandom_range(0, 99) < 15) ? 1 : 0,
           ($urandom_range(0, 99) < 15) ? 1 : 0,
           mon, ym);
    end

    step("drain", 0, 0, 0, 0, mon, ym);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_day_31.md
Name: counter_day_31

Overview:
- Day-of-month counter, 1..28/29/30/31, whose upper bound is selected by the current month and by the year-mod-4 value.
- Its registered carry_out drives the month counter's inc_auto input, so it is the producer side of the month-increment interface.
- Its inc_auto input is driven by the hour counter's carry (end of day).
- Manual set buttons step the day up or down, wrapping inside the current month.

Parameters:
RESET_DAY, 1, day value loaded on reset; legal range 1..28.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
inc_auto  input  1  one-cycle end-of-day pulse from the hour counter
inc_manual  input  1  one-cycle manual increment pulse, already debounced
dec_manual  input  1  one-cycle manual decrement pulse, already debounced
month  input  4  current month, 1..12, taken from the month counter value
year_mod4  input  2  year modulo 4; 0 means a leap-year candidate
value  output  5  current day, 1..31
carry_out  output  1  registered one-cycle pulse on an auto wrap to 1; connects to the month counter's inc_auto
days_max  output  5  combinational days-in-month for the current month/year

Behaviour:
- Reset: on a clk edge with rst=1, value=RESET_DAY and carry_out=0. Reset overrides all other inputs in that cycle.
- days_max (combinational):
  - months 4, 6, 9, 11 -> 30
  - month 2 -> 28, or 29 (see Optional Feature)
  - months 1, 3, 5, 7, 8, 10, 12 -> 31
  - illegal month values 0 and 13..15 -> 31
- carry_out defaults to 0 every cycle. It is high for exactly one cycle, in the same cycle value becomes 1 through an auto wrap. The month counter therefore advances one clk after the day wraps.
- Per-cycle action, highest priority first:
  1. Clamp: if value > days_max (the month/year changed under the counter), value <= days_max. All increment/decrement inputs are ignored that cycle and carry_out=0.
  2. dec_manual: value <= (value==1) ? days_max : value-1. carry_out=0.
  3. inc_manual: value <= (value>=days_max) ? 1 : value+1. carry_out=0; a manual wrap never carries into the month.
  4. inc_auto: if value>=days_max, value <= 1 and carry_out <= 1; otherwise value <= value+1.
  5. No input asserted: value holds.
- When several pulses arrive in one cycle, only the highest-priority one is acted on. The others are dropped, not queued.
- The counter never holds 0 or a value above 31. Arithmetic is 5-bit unsigned; comparisons use >= so that a stale out-of-range value still wraps safely.
- Back-to-back inc_auto on consecutive cycles is legal; each pulse advances the counter once.
- Clamp latency: one cycle after month/year_mod4 change.
- Asserting rst mid-sequence (including in the same cycle as a carry) forces carry_out=0 on that edge.

Optional Feature:
- Macro: LEAP_YEAR_EN.
- Defined: when month==2, days_max = 29 if year_mod4==0, else 28.
- Undefined: when month==2, days_max = 28 always. year_mod4 remains a port but is ignored; no logic depends on it.
- No other behaviour differs between the two builds.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> value=1, carry_out=0; value holds 1 with no pulses.
- Month-end auto wrap: month=1, drive value to 31 by 30 inc_auto pulses, then one more inc_auto -> value=1 and carry_out=1 for exactly one cycle. Repeat with month=4: the wrap occurs at 30.
- February:
  - month=2, year_mod4=1, day 28 + inc_auto -> value=1 with carry.
  - With LEAP_YEAR_EN and year_mod4=0: 28 -> 29, then 29 -> 1 with carry.
  - Without the macro and year_mod4=0: 28 -> 1 with carry.
- Manual wrap: month=6, value=1, dec_manual -> value=30, carry_out=0. Then inc_manual -> value=1, carry_out=0.
- Clamp: value=31 with month=1, then switch month to 2 (year_mod4=1) while pulsing inc_auto in the same cycle -> next cycle value=28, carry_out=0, and the inc_auto pulse is dropped.
- Simultaneous pulses:
  - value=10 with inc_auto=inc_manual=dec_manual=1 -> value=9, carry_out=0.
  - month=3, value=31 with inc_auto=inc_manual=1 -> value=1, carry_out=0.
